led_driver: RTL

Output-side companion to the button debouncer: a command-driven LED driver that holds, blinks, or pulses a single LED output with millisecond-accurate phase timing. A controller issues one mode command over a valid/ready handshake. The block then sequences on/off phases autonomously. It sits at the board-facing edge of the design, opposite the debounced button inputs, and gives the user visible feedback.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_driver_phase_timer.sv | 27 ++
 rtl/led_driver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED driver: command modes, FSM states and count width.
package led_pkg;

    localparam int unsigned COUNT_W = 4;
    localparam int unsigned MODE_W  = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_PULSE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE_OFF = 3'd0,
        ST_IDLE_ON  = 3'd1,
        ST_ON_PH    = 3'd2,
        ST_OFF_PH   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/led_driver_phase_timer.sv
// Loadable down-counter; flags the last cycle of a phase and parks at zero.
module phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expired_c
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A count of one is the final cycle of the loaded phase.
    assign o_expired_c = (r_count == WIDTH'(1));

endmodule

// File: rtl/led_driver.sv
// Command-driven LED driver: static on/off, continuous blink, or N-blink pulse.
module led_driver
    import led_pkg::*;
#(
    parameter int unsigned clk_freq   = 95000,
    parameter int unsigned on_ms      = 100,
    parameter int unsigned off_ms     = 100,
    parameter bit          active_low = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [MODE_W-1:0]  cmd_mode,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               led_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned ON_TICKS  = on_ms * clk_freq;
    localparam int unsigned OFF_TICKS = off_ms * clk_freq;
    localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TIMER_W   = $clog2(MAX_TICKS + 1);

    if (ON_TICKS < 1 || OFF_TICKS < 1) begin : g_tick_check
        $error("led_driver: ON_TICKS and OFF_TICKS must both be at least 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [COUNT_W-1:0]   r_remaining;
    logic [COUNT_W-1:0]   w_remaining_next;
    logic                 r_pulse;
    logic                 w_pulse_next;
    logic                 r_cmd_ready;
    logic                 r_led_out;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_ready_next;
    logic                 w_led_next;
    logic                 w_busy_next;
    logic                 w_done_next;
    logic                 w_accept;
    logic                 w_load;
    logic [TIMER_W-1:0]   w_load_val;
    logic                 w_expired;

    phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .o_expired_c (w_expired)
    );

    assign w_accept = cmd_valid && r_cmd_ready;

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE_OFF;
            r_remaining <= '0;
            r_pulse     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_led_out   <= active_low;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_pulse     <= w_pulse_next;
            r_cmd_ready <= w_ready_next;
            r_led_out   <= w_led_next ^ active_low;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_pulse_next     = r_pulse;
        w_load           = 1'b0;
        w_load_val       = TIMER_W'(ON_TICKS);

        if (w_accept) begin
            unique case (cmd_mode)
                MODE_OFF: begin
                    w_state_next = ST_IDLE_OFF;
                    w_pulse_next = 1'b0;
                end
                MODE_ON: begin
                    w_state_next = ST_IDLE_ON;
                    w_pulse_next = 1'b0;
                end
                MODE_BLINK: begin
                    w_state_next = ST_ON_PH;
                    w_pulse_next = 1'b0;
                    w_load       = 1'b1;
                end
                MODE_PULSE: begin
                    w_pulse_next     = 1'b1;
                    w_remaining_next = cmd_count;
                    if (cmd_count == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ON_PH;
                        w_load       = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (r_state)
                ST_ON_PH: begin
                    if (w_expired) begin
                        w_state_next = ST_OFF_PH;
                        w_load       = 1'b1;
                        w_load_val   = TIMER_W'(OFF_TICKS);
                    end
                end
                ST_OFF_PH: begin
                    if (w_expired) begin
                        if (r_pulse) begin
                            w_remaining_next = r_remaining - COUNT_W'(1);
                        end
                        if (r_pulse && r_remaining == COUNT_W'(1)) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_ON_PH;
                            w_load       = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE_OFF;
                    w_pulse_next = 1'b0;
                end
                default: ;
            endcase
        end

        w_led_next   = (w_state_next == ST_IDLE_ON) || (w_state_next == ST_ON_PH);
        w_busy_next  = (w_state_next == ST_ON_PH) || (w_state_next == ST_OFF_PH)
                    || (w_state_next == ST_DONE);
        w_done_next  = (w_state_next == ST_DONE);
        w_ready_next = (w_state_next == ST_IDLE_OFF) || (w_state_next == ST_IDLE_ON)
                    || (((w_state_next == ST_ON_PH) || (w_state_next == ST_OFF_PH))
                        && !w_pulse_next);
    end

    assign cmd_ready = r_cmd_ready;
    assign led_out   = r_led_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
